posit_decode_pipe: RTL
======================

POSIT_DECODE_PIPE -- requirements
Module: posit_decode_pipe

Interface
REQ-001 SHALL have parameter N, default 16: posit word width; legal range 4..32.
REQ-002 SHALL have parameter es, default 1: exponent field width; legal range 0..N-4.
REQ-003 SHALL have parameter Bs, default ceil(log2(N)): regime magnitude width.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port in_valid, input, 1 bit: in_data is valid this cycle.
REQ-007 SHALL have port in_ready, output, 1 bit: block accepts in_data this cycle.
REQ-008 SHALL have port in_data, input, N bits: posit word.
REQ-009 SHALL have port out_valid, output, 1 bit: decoded fields are valid.
REQ-010 SHALL have port out_ready, input, 1 bit: consumer accepts the fields this cycle.
REQ-011 SHALL have port sign, output, 1 bit: posit sign bit.
REQ-012 SHALL have port is_zero, output, 1 bit: in_data was all zeros.
REQ-013 SHALL have port is_nar, output, 1 bit: in_data was 1 followed by N-1 zeros.
REQ-014 SHALL have port regime, output, Bs+1 bits signed: regime value k.
REQ-015 SHALL have port exp, output, max(es,1) bits: exponent field; all zeros when es=0.
REQ-016 SHALL have port mant, output, N-es-2 bits: hidden 1 followed by fraction bits, left-aligned, zero-filled.
REQ-017 SHALL have port eff_e, output, Bs+es+1 bits signed: k*2^es + exp.
REQ-018 SHALL have port occupancy, output, 2 bits: number of valid stages, 0..3.

Function
REQ-019 SHALL run three pipeline stages: S1 registers the sign and the magnitude (two's complement of in_data[N-2:0] when the sign is 1), together with the zero and NaR flags; S2 registers the regime run length and k; S3 registers exp, mant and eff_e.
REQ-020 SHALL transfer a word in when in_valid && in_ready, and a result out when out_valid && out_ready.
REQ-021 SHALL use a global advance enable adv = !out_valid || out_ready; all stages and their valid bits shift only when adv=1.
REQ-022 SHALL drive in_ready = adv combinationally, giving a fixed latency of 3 cycles from acceptance to out_valid when there is no stall.
REQ-023 SHALL hold all output fields stable while out_valid=1 and out_ready=0.
REQ-024 SHALL form the regime from the magnitude bits below the sign: r = leading regime bit, run = count of consecutive bits equal to r, saturating at N-1.
REQ-025 SHALL set k = run-1 when r=1 and k = -run when r=0.
REQ-026 SHALL take the es bits following the regime terminator as exp; bits beyond the word end read as 0.
REQ-027 SHALL place the remaining bits after exp into mant below the hidden 1; mant is truncated or zero-padded to width N-es-2.
REQ-028 SHALL force regime, exp, mant and eff_e to 0 when is_zero or is_nar is set; sign SHALL be 0 for zero and 1 for NaR.
REQ-029 SHALL update occupancy each cycle as the count of S1..S3 valid bits.
REQ-030 SHALL fill pipeline bubbles correctly: an invalid input advances as a bubble; out_valid follows the S3 valid bit only.
REQ-031 SHALL deliver words in order with no loss or duplication under any pattern of in_valid and out_ready.

Reset
REQ-032 SHALL clear all valid bits on reset; out_valid=0, occupancy=0, and all field outputs = 0 on the cycle after reset is sampled high.
REQ-033 SHALL hold in_ready=1 during reset; data in flight during reset is discarded and words presented while reset=1 are not captured.

Verification (N=8, es=1 unless stated)
REQ-034 SHALL pass this case: in_data 0x40, out_ready=1 -> after 3 cycles sign=0, regime=0, exp=0, mant=5'b10000, eff_e=0.
REQ-035 SHALL pass this case: 0x00 then 0x80 back-to-back -> is_zero=1 with all fields 0, then is_nar=1 with sign=1, on consecutive cycles.
REQ-036 SHALL pass this case: 0x7F -> regime=6, eff_e=12; 0x01 -> regime=-6, eff_e=-12; 0xC0 -> sign=1, regime=0, eff_e=0.
REQ-037 SHALL pass this case: 0x50 -> exp=1, eff_e=1; 0x48 -> mant=5'b11000.
REQ-038 SHALL pass this case: stream of 6 words with out_ready low for 4 cycles mid-stream -> in_ready=0 while stalled, occupancy reaches 3, outputs held, all 6 results in order.
REQ-039 SHALL pass this case: reset asserted with occupancy=2 -> next cycle out_valid=0 and occupancy=0, and no stale result appears afterwards.

Source files
------------

// File: rtl/posit_decode_pipe.sv
// Three-stage posit decoder: sign/magnitude, then regime scan, then exponent/fraction extraction.
// One global advance enable moves every stage together under valid/ready flow control.
module posit_decode_pipe #(
    parameter int unsigned N  = 16,
    parameter int unsigned es = 1,
    parameter int unsigned Bs = $clog2(N)
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [N-1:0]                   in_data,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic                           sign,
    output logic                           is_zero,
    output logic                           is_nar,
    output logic signed [Bs:0]             regime,
    output logic [((es > 0) ? es : 1)-1:0] exp,
    output logic [N-es-3:0]                mant,
    output logic signed [Bs+es:0]          eff_e,
    output logic [1:0]                     occupancy
);

    localparam int unsigned MW = N - 1;
    localparam int unsigned EW = (es > 0) ? es : 1;
    localparam int unsigned FW = N - es - 3;
    localparam int unsigned KW = Bs + 1;
    localparam int unsigned XW = Bs + es + 1;

    logic adv;

    logic          s1_v_q, s1_v_d, s1_sign_q, s1_sign_d;
    logic          s1_zero_q, s1_zero_d, s1_nar_q, s1_nar_d;
    logic [MW-1:0] s1_mag_q, s1_mag_d;

    logic                 s2_v_q, s2_v_d, s2_sign_q, s2_sign_d;
    logic                 s2_zero_q, s2_zero_d, s2_nar_q, s2_nar_d;
    logic [MW-1:0]        s2_mag_q, s2_mag_d;
    logic [Bs-1:0]        s2_run_q, s2_run_d;
    logic signed [KW-1:0] s2_k_q, s2_k_d;

    logic                 s3_v_q, s3_v_d, sign_q, sign_d;
    logic                 is_zero_q, is_zero_d, is_nar_q, is_nar_d;
    logic signed [KW-1:0] regime_q, regime_d;
    logic [EW-1:0]        exp_q, exp_d;
    logic [FW:0]          mant_q, mant_d;
    logic signed [XW-1:0] eff_e_q, eff_e_d;
    logic [1:0]           occ_q, occ_d;

    logic                 run_open;
    logic [Bs-1:0]        run_len;
    logic signed [KW-1:0] k_val;
    logic [KW-1:0]        shamt;
    logic [MW-3:0]        shifted;
    logic [1:0]           shift_unused;
    logic [EW-1:0]        exp_f;
    logic [FW:0]          mant_f;
    logic signed [XW-1:0] eff_f;

    // A stalled output blocks everything; reset forces ready so nothing upstream waits on it.
    always_comb begin
        adv      = !s3_v_q || out_ready;
        in_ready = adv || reset;
    end

    // Regime scan: run of bits equal to the leading magnitude bit, saturating at N-1.
    always_comb begin
        run_open = 1'b1;
        run_len  = '0;
        for (int i = int'(MW) - 1; i >= 0; i--) begin
            if (run_open && (s1_mag_q[i] == s1_mag_q[MW-1])) begin
                run_len = run_len + Bs'(1);
            end else begin
                run_open = 1'b0;
            end
        end
        k_val = s1_mag_q[MW-1] ? (KW'(run_len) - KW'(1)) : (KW'(0) - KW'(run_len));
    end

    // Dropping regime and terminator leaves exp then fraction at the top; bits past the word read 0.
    always_comb begin
        shamt                   = {1'b0, s2_run_q} + KW'(1);
        {shifted, shift_unused} = s2_mag_q << shamt;
        if (es > 0) begin
            exp_f = shifted[MW-3 -: EW];
        end else begin
            exp_f = '0;
        end
        mant_f = {1'b1, shifted[FW-1:0]};
        eff_f  = (XW'(s2_k_q) << es) + XW'(exp_f);
    end

    always_comb begin
        s1_v_d    = s1_v_q;
        s1_sign_d = s1_sign_q;
        s1_zero_d = s1_zero_q;
        s1_nar_d  = s1_nar_q;
        s1_mag_d  = s1_mag_q;
        s2_v_d    = s2_v_q;
        s2_sign_d = s2_sign_q;
        s2_zero_d = s2_zero_q;
        s2_nar_d  = s2_nar_q;
        s2_mag_d  = s2_mag_q;
        s2_run_d  = s2_run_q;
        s2_k_d    = s2_k_q;
        s3_v_d    = s3_v_q;
        sign_d    = sign_q;
        is_zero_d = is_zero_q;
        is_nar_d  = is_nar_q;
        regime_d  = regime_q;
        exp_d     = exp_q;
        mant_d    = mant_q;
        eff_e_d   = eff_e_q;
        if (adv) begin
            s1_v_d    = in_valid;
            s1_sign_d = in_data[N-1];
            s1_mag_d  = in_data[N-1] ? (~in_data[N-2:0] + MW'(1)) : in_data[N-2:0];
            s1_zero_d = (in_data == '0);
            s1_nar_d  = in_data[N-1] && (in_data[N-2:0] == '0);

            s2_v_d    = s1_v_q;
            s2_sign_d = s1_sign_q;
            s2_zero_d = s1_zero_q;
            s2_nar_d  = s1_nar_q;
            s2_mag_d  = s1_mag_q;
            s2_run_d  = run_len;
            s2_k_d    = k_val;

            s3_v_d    = s2_v_q;
            sign_d    = s2_sign_q;
            is_zero_d = s2_zero_q;
            is_nar_d  = s2_nar_q;
            if (s2_zero_q || s2_nar_q) begin
                regime_d = '0;
                exp_d    = '0;
                mant_d   = '0;
                eff_e_d  = '0;
            end else begin
                regime_d = s2_k_q;
                exp_d    = exp_f;
                mant_d   = mant_f;
                eff_e_d  = eff_f;
            end
        end
        occ_d = 2'(s1_v_d) + 2'(s2_v_d) + 2'(s3_v_d);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_v_q    <= 1'b0;
            s1_sign_q <= 1'b0;
            s1_zero_q <= 1'b0;
            s1_nar_q  <= 1'b0;
            s1_mag_q  <= '0;
            s2_v_q    <= 1'b0;
            s2_sign_q <= 1'b0;
            s2_zero_q <= 1'b0;
            s2_nar_q  <= 1'b0;
            s2_mag_q  <= '0;
            s2_run_q  <= '0;
            s2_k_q    <= '0;
            s3_v_q    <= 1'b0;
            sign_q    <= 1'b0;
            is_zero_q <= 1'b0;
            is_nar_q  <= 1'b0;
            regime_q  <= '0;
            exp_q     <= '0;
            mant_q    <= '0;
            eff_e_q   <= '0;
            occ_q     <= '0;
        end else begin
            s1_v_q    <= s1_v_d;
            s1_sign_q <= s1_sign_d;
            s1_zero_q <= s1_zero_d;
            s1_nar_q  <= s1_nar_d;
            s1_mag_q  <= s1_mag_d;
            s2_v_q    <= s2_v_d;
            s2_sign_q <= s2_sign_d;
            s2_zero_q <= s2_zero_d;
            s2_nar_q  <= s2_nar_d;
            s2_mag_q  <= s2_mag_d;
            s2_run_q  <= s2_run_d;
            s2_k_q    <= s2_k_d;
            s3_v_q    <= s3_v_d;
            sign_q    <= sign_d;
            is_zero_q <= is_zero_d;
            is_nar_q  <= is_nar_d;
            regime_q  <= regime_d;
            exp_q     <= exp_d;
            mant_q    <= mant_d;
            eff_e_q   <= eff_e_d;
            occ_q     <= occ_d;
        end
    end

    assign out_valid = s3_v_q;
    assign sign      = sign_q;
    assign is_zero   = is_zero_q;
    assign is_nar    = is_nar_q;
    assign regime    = regime_q;
    assign exp       = exp_q;
    assign mant      = mant_q;
    assign eff_e     = eff_e_q;
    assign occupancy = occ_q;

endmodule
